// File: rtl/program_loader_if.sv
// Instruction-memory write port driven by program_loader, plus its boot-status outputs.
interface program_loader_if #(
  parameter int ADDR = 8,
  parameter int WORD = 12
) ();
  logic            program_write;
  logic [ADDR-1:0] program_addr;
  logic [WORD-1:0] program_cmd;
  logic            cpu_hold;
  logic            load_done;
  logic            load_error;

  modport master (
    output program_write, program_addr, program_cmd,
    output cpu_hold, load_done, load_error
  );

  modport slave (
    input program_write, program_addr, program_cmd,
    input cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/program_loader.sv
// Serial (8N1) bootloader: decodes an A5-framed image from rx and writes it into instruction memory.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR         = 8,
  parameter int WORD         = 12,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  program_loader_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd6;
`endif

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  // Byte receiver; shift_q holds the completed byte while byte_valid_q is high.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
          cnt_d      = '0;
          bit_d      = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d        = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end
      end
    endcase
  end

  logic [2:0]      ld_state_q, ld_state_d;
  logic            write_q, write_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [WORD-1:0] cmd_q, cmd_d;
  logic            hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [ADDR-1:0] idx_q, idx_d, last_q, last_d;
  logic [WORD-9:0] hi_q, hi_d;
  logic [ADDR-1:0] count_ext;
  logic            in_frame;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  assign count_ext = ADDR'(shift_q);
  // Line errors only abort an active frame; DONE/ERROR just watch for a new sync byte.
  assign in_frame  = (ld_state_q == ST_COUNT) || (ld_state_q == ST_HI) || (ld_state_q == ST_LO)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     || (ld_state_q == ST_CHECK)
`endif
                     ;

  always_comb begin
    ld_state_d = ld_state_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    idx_d      = idx_q;
    last_d     = last_q;
    hi_d       = hi_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (frame_err_q && in_frame) begin
      ld_state_d = ST_ERROR;
      err_d      = 1'b1;
    end else if (byte_valid_q) begin
      case (ld_state_q)
        ST_COUNT: begin
          last_d     = count_ext - 1'b1;  // count 0 wraps to 2^ADDR words
          ld_state_d = ST_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = shift_q;
`endif
        end
        ST_HI: begin
          hi_d       = shift_q[WORD-9:0];
          ld_state_d = ST_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q;
`endif
        end
        ST_LO: begin
          write_d    = 1'b1;
          addr_d     = idx_q;
          cmd_d      = {hi_q, shift_q};
          idx_d      = idx_q + 1'b1;
          ld_state_d = ST_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q;
          if (idx_q == last_q) ld_state_d = ST_CHECK;
`else
          if (idx_q == last_q) begin
            ld_state_d = ST_DONE;
            done_d     = 1'b1;
            hold_d     = 1'b0;
          end
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (shift_q == csum_q) begin
            ld_state_d = ST_DONE;
            done_d     = 1'b1;
            hold_d     = 1'b0;
          end else begin
            ld_state_d = ST_ERROR;
            err_d      = 1'b1;
          end
        end
`endif
        default: begin
          if (shift_q == 8'hA5) begin
            ld_state_d = ST_COUNT;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            idx_d      = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_state_q   <= ST_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      cmd_q        <= '0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      last_q       <= '0;
      hi_q         <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_state_q   <= ld_state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      hi_q         <= hi_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.program_write = write_q;
  assign bus.program_addr  = addr_q;
  assign bus.program_cmd   = cmd_q;
  assign bus.cpu_hold      = hold_q;
  assign bus.load_done     = done_q;
  assign bus.load_error    = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the stimulus, popped by a monitor.
module tb_program_loader;
  localparam int ADDR = 8;
  localparam int WORD = 12;
  localparam int CPB  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  program_loader_if #(.ADDR(ADDR), .WORD(WORD)) bus ();

  program_loader #(.ADDR(ADDR), .WORD(WORD), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [ADDR+WORD-1:0] exp_q[$];
  logic [7:0] fq[$];

  // Monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (reset && bus.program_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%0h cmd=%0h required no write",
                 bus.program_addr, bus.program_cmd);
      end else begin
        logic [ADDR+WORD-1:0] e;
        e = exp_q.pop_front();
        if ({bus.program_addr, bus.program_cmd} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h cmd=%0h required addr=%0h cmd=%0h",
                   bus.program_addr, bus.program_cmd, e[ADDR+WORD-1:WORD], e[WORD-1:0]);
        end else begin
          $display("write addr=%0h cmd=%0h ok", bus.program_addr, bus.program_cmd);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  // Sends count + word bytes from fq, then the checksum byte when enabled (xor_flip corrupts it).
  task automatic send_body(input logic [7:0] xor_flip);
    logic [7:0] sum;
    sum = 8'h00;
    foreach (fq[i]) begin
      sum ^= fq[i];
      send_byte(fq[i], 1'b1);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(sum ^ xor_flip, 1'b1);
`else
    if (xor_flip != 8'h00) $display("note: checksum disabled, flip %0h unused", xor_flip);
`endif
  endtask

  task automatic push_write(input logic [ADDR-1:0] a, input logic [WORD-1:0] c);
    exp_q.push_back({a, c});
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done, input logic err);
    check({tag, "_hold"}, {31'd0, bus.cpu_hold}, {31'd0, hold});
    check({tag, "_done"}, {31'd0, bus.load_done}, {31'd0, done});
    check({tag, "_error"}, {31'd0, bus.load_error}, {31'd0, err});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write"}, {31'd0, bus.program_write}, 32'd0);
    check({tag, "_addr"}, {24'd0, bus.program_addr}, 32'd0);
    check({tag, "_cmd"}, {20'd0, bus.program_cmd}, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;
    tick(3);

    // Idle traffic before sync is ignored
    send_byte(8'h00, 1'b1);
    check("hold_after_00", {31'd0, bus.cpu_hold}, 32'd0);
    send_byte(8'h55, 1'b1);
    check("hold_after_55", {31'd0, bus.cpu_hold}, 32'd0);

    // Short glitch: a false start would leave the receiver busy and garble the next sync byte
    rx = 1'b0;
    tick(CPB/2 - 3);
    rx = 1'b1;
    tick(CPB);

    // Main frame A5 02 0A 12 03 FF
    push_write(8'd0, 12'hA12);
    push_write(8'd1, 12'h3FF);
    send_byte(8'hA5, 1'b1);
    check_status("sync", 1'b1, 1'b0, 1'b0);
    fq = '{8'h02, 8'h0A, 8'h12, 8'h03, 8'hFF};
    send_body(8'h00);
    check_status("main_done", 1'b0, 1'b1, 1'b0);
    check("main_queue_empty", exp_q.size(), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push_write(8'd0, 12'hA12);
    push_write(8'd1, 12'h3FF);
    send_byte(8'hA5, 1'b1);
    send_body(8'h01);
    check_status("bad_sum", 1'b1, 1'b0, 1'b1);
    check("bad_sum_queue_empty", exp_q.size(), 32'd0);
`endif

    // Framing error on third byte, then trailing bytes must not write
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h0A, 1'b0);
    check_status("frame_err", 1'b1, 1'b0, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hFF, 1'b1);
    check_status("after_err", 1'b1, 1'b0, 1'b1);

    // Recovery frame; upper high-byte bits beyond WORD are dropped
    push_write(8'd0, 12'h3C4);
    send_byte(8'hA5, 1'b1);
    check_status("recover_sync", 1'b1, 1'b0, 1'b0);
    fq = '{8'h01, 8'hF3, 8'hC4};
    send_body(8'h00);
    check_status("recover_done", 1'b0, 1'b1, 1'b0);

    // Reset after first word strobe
    push_write(8'd0, 12'hA12);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h12, 1'b1);
    check("pre_reset_queue_empty", exp_q.size(), 32'd0);
    check("pre_reset_hold", {31'd0, bus.cpu_hold}, 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_all_zero("async_reset");
    tick(2);
    reset = 1'b1;
    tick(2);

    push_write(8'd0, 12'h123);
    push_write(8'd1, 12'h456);
    send_byte(8'hA5, 1'b1);
    fq = '{8'h02, 8'h01, 8'h23, 8'h04, 8'h56};
    send_body(8'h00);
    check_status("reload_done", 1'b0, 1'b1, 1'b0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
